// File: rtl/ip_cksum_ttl_ctrl.sv
// IPv4 header sequencer: holds the first two beats, verifies the header checksum
// with one shared ones'-complement adder, decrements TTL with an incremental checksum patch.
`timescale 1ns/1ps
module ip_cksum_ttl_ctrl #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int BAD_CKSUM_POS        = 32,
  parameter int TTL_EXP_POS          = 33
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic [31:0]                       good_count,
  output logic [31:0]                       bad_count,
  output logic [31:0]                       ttl_exp_count
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HOLD1, ST_SUM, ST_FOLD, ST_EMIT0, ST_EMIT1, ST_PASS
  } state_t;

  state_t state, state_next;
  logic   s_ready;

  // Held header beats
  logic [C_S_AXIS_DATA_WIDTH-1:0]   b0_data, b1_data;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] b0_strb, b1_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  b0_user, b1_user;
  logic                             b0_last, b1_last;

  logic [15:0] acc;
  logic [3:0]  word_idx;
  logic        flag_bad, flag_exp;
  logic        pass_last_in;

  logic s_hs, m_hs;
  assign s_hs = S_AXIS_TVALID && S_AXIS_TREADY;
  assign m_hs = M_AXIS_TVALID && M_AXIS_TREADY;

  logic ipv4_hdr;
  assign ipv4_hdr = (b0_data[159:144] == 16'h0800) && (b0_data[143:136] == 8'h45);

  // Word k of the 20-byte header; the last word spills into beat 1.
  logic [15:0] cur_word;
  always_comb begin
    // NOTE: a default before any conditional assignment keeps combinational blocks latch-free.
    cur_word = b1_data[255:240];
    for (int i = 0; i < 9; i++) begin
      if (word_idx == 4'(i)) cur_word = b0_data[143-16*i -: 16];
    end
  end

  logic [16:0] sum_t;
  logic [15:0] acc_next;
  assign sum_t    = {1'b0, acc} + {1'b0, cur_word};
  assign acc_next = sum_t[15:0] + {15'd0, sum_t[16]};

  logic       hdr_ok, ttl_live;
  logic [7:0] ttl;
  assign ttl      = b0_data[79:72];
  assign hdr_ok   = (acc == 16'hFFFF);
  assign ttl_live = (ttl > 8'd1);

  // TTL-1 lowers the (TTL,proto) word by 0x0100, so the checksum rises by 0x0100.
  logic [16:0] cks_t;
  logic [15:0] cks_new;
  assign cks_t   = {1'b0, b0_data[63:48]} + 17'h00100;
  assign cks_new = cks_t[15:0] + {15'd0, cks_t[16]};

  logic [C_S_AXIS_DATA_WIDTH-1:0] b0_patched;
  always_comb begin
    b0_patched         = b0_data;
    b0_patched[79:72]  = ttl - 8'd1;
    b0_patched[63:48]  = cks_new;
  end

  logic [C_S_AXIS_TUSER_WIDTH-1:0] fold_flags, held_flags;
  always_comb begin
    fold_flags                = '0;
    fold_flags[BAD_CKSUM_POS] = !hdr_ok;
    fold_flags[TTL_EXP_POS]   = hdr_ok && !ttl_live;
    held_flags                = '0;
    held_flags[BAD_CKSUM_POS] = flag_bad;
    held_flags[TTL_EXP_POS]   = flag_exp;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) state <= ST_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (S_AXIS_TVALID) state_next = S_AXIS_TLAST ? ST_EMIT0 : ST_HOLD1;
      end
      ST_HOLD1: begin
        s_ready = 1'b1;
        if (S_AXIS_TVALID) state_next = ipv4_hdr ? ST_SUM : ST_EMIT0;
      end
      ST_SUM:   if (word_idx == 4'd9) state_next = ST_FOLD;
      ST_FOLD:  state_next = ST_EMIT0;
      ST_EMIT0: if (m_hs) state_next = b0_last ? ST_IDLE : ST_EMIT1;
      ST_EMIT1: if (m_hs) state_next = b1_last ? ST_IDLE : ST_PASS;
      ST_PASS: begin
        // Stop accepting once the tail is in, so the next packet waits for the final handshake.
        s_ready = (!M_AXIS_TVALID || M_AXIS_TREADY) && !pass_last_in;
        if (m_hs && M_AXIS_TLAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign S_AXIS_TREADY = s_ready && !AXI_RESET;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge AXI_ACLK) begin
    // NOTE: the held beats are plain registers, so they are cleared with everything else on reset.
    if (AXI_RESET) begin
      b0_data <= '0; b0_strb <= '0; b0_user <= '0; b0_last <= 1'b0;
      b1_data <= '0; b1_strb <= '0; b1_user <= '0; b1_last <= 1'b0;
      acc <= '0; word_idx <= '0;
      flag_bad <= 1'b0; flag_exp <= 1'b0; pass_last_in <= 1'b0;
      M_AXIS_TDATA <= '0; M_AXIS_TSTRB <= '0; M_AXIS_TUSER <= '0;
      M_AXIS_TVALID <= 1'b0; M_AXIS_TLAST <= 1'b0;
      good_count <= '0; bad_count <= '0; ttl_exp_count <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (s_hs) begin
          b0_data <= S_AXIS_TDATA; b0_strb <= S_AXIS_TSTRB;
          b0_user <= S_AXIS_TUSER; b0_last <= S_AXIS_TLAST;
          flag_bad <= 1'b0; flag_exp <= 1'b0; pass_last_in <= 1'b0;
          if (S_AXIS_TLAST) begin
            M_AXIS_TDATA <= S_AXIS_TDATA; M_AXIS_TSTRB <= S_AXIS_TSTRB;
            M_AXIS_TUSER <= S_AXIS_TUSER; M_AXIS_TLAST <= 1'b1;
            M_AXIS_TVALID <= 1'b1;
          end
        end
        ST_HOLD1: if (s_hs) begin
          b1_data <= S_AXIS_TDATA; b1_strb <= S_AXIS_TSTRB;
          b1_user <= S_AXIS_TUSER; b1_last <= S_AXIS_TLAST;
          acc <= '0; word_idx <= '0;
          if (!ipv4_hdr) begin
            M_AXIS_TDATA <= b0_data; M_AXIS_TSTRB <= b0_strb;
            M_AXIS_TUSER <= b0_user; M_AXIS_TLAST <= b0_last;
            M_AXIS_TVALID <= 1'b1;
          end
        end
        ST_SUM: begin
          acc      <= acc_next;
          word_idx <= word_idx + 4'd1;
        end
        ST_FOLD: begin
          flag_bad <= !hdr_ok;
          flag_exp <= hdr_ok && !ttl_live;
          M_AXIS_TDATA  <= (hdr_ok && ttl_live) ? b0_patched : b0_data;
          M_AXIS_TSTRB  <= b0_strb;
          M_AXIS_TUSER  <= b0_user | fold_flags;
          M_AXIS_TLAST  <= b0_last;
          M_AXIS_TVALID <= 1'b1;
          if (hdr_ok) good_count <= good_count + 32'd1;
          else        bad_count  <= bad_count + 32'd1;
          if (hdr_ok && !ttl_live) ttl_exp_count <= ttl_exp_count + 32'd1;
        end
        ST_EMIT0: if (m_hs) begin
          if (b0_last) M_AXIS_TVALID <= 1'b0;
          else begin
            M_AXIS_TDATA <= b1_data; M_AXIS_TSTRB <= b1_strb;
            M_AXIS_TUSER <= b1_user | held_flags; M_AXIS_TLAST <= b1_last;
          end
        end
        ST_EMIT1: if (m_hs) M_AXIS_TVALID <= 1'b0;
        ST_PASS: begin
          if (s_hs) begin
            M_AXIS_TDATA <= S_AXIS_TDATA; M_AXIS_TSTRB <= S_AXIS_TSTRB;
            M_AXIS_TUSER <= S_AXIS_TUSER; M_AXIS_TLAST <= S_AXIS_TLAST;
            M_AXIS_TVALID <= 1'b1;
            if (S_AXIS_TLAST) pass_last_in <= 1'b1;
          end else if (m_hs) begin
            M_AXIS_TVALID <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
